// File: rtl/multi_dice.sv
// multi_dice: N-die roller with rejection sampling, a per-die hold mask,
// a roll-done pulse, a binary sum and a multiplexed 7-segment driver.
//
// Ports:
//   CLK      clock
//   RST_N    asynchronous active-low reset (released synchronously upstream)
//   ROLL     roll request, acts on its rising edge
//   HOLD     per-die freeze mask, captured when a roll starts
//   VALUES   die i value in [4i+3:4i], binary 1..SIDES
//   SUM      sum of all die values
//   ROLLING  high while a roll is in progress
//   DONE     one-cycle pulse when a roll completes
//   SEG      [6:0] segments g..a of the scanned die (active-high), [7] dp
//   DIG      one-hot digit enable, bit i selects die i
module multi_dice #(
  parameter int          NDICE     = 2,
  parameter int          SIDES     = 6,
  parameter int          DIV_START = 2,
  parameter int          DIV_END   = 160,
  parameter int          SCAN_DIV  = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ROLL,
  input  logic [NDICE-1:0]     HOLD,
  output logic [4*NDICE-1:0]   VALUES,
  output logic [5:0]           SUM,
  output logic                 ROLLING,
  output logic                 DONE,
  output logic [7:0]           SEG,
  output logic [NDICE-1:0]     DIG
);

  localparam int          W         = $clog2(SIDES);
  localparam int          SCW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [15:0] CAND_MASK = 16'((1 << W) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ROLL, ST_SETTLE} state_t;

  state_t           state_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      rc_q;
  logic             roll_q;
  logic [7:0]       cnt_q;
  logic [7:0]       div_q;
  logic [NDICE-1:0] held_q;
  logic [NDICE-1:0] pending_q, pending_d;
  logic [3:0]       die_q [NDICE];
  logic             rolling_q;
  logic             done_q;
  logic [SCW-1:0]   scan_q, scan_d;
  logic [NDICE-1:0] dig_q, dig_rot;

  logic [15:0]      rnd;
  logic             roll_edge;
  logic             tick;
  logic             scan_wrap;
  logic [3:0]       cand [NDICE];
  logic [NDICE-1:0] accept;
  logic [3:0]       sel_val;
  logic [6:0]       seg7;
  logic [5:0]       sum_v;

  // Randomness: LFSR plus a free-running counter, both advancing every cycle
  assign lfsr_d    = {lfsr_q[0], lfsr_q[15], lfsr_q[14] ^ lfsr_q[0], lfsr_q[13] ^ lfsr_q[0],
                      lfsr_q[12], lfsr_q[11] ^ lfsr_q[0], lfsr_q[10:1]};
  assign rnd       = lfsr_q + rc_q;
  assign roll_edge = ROLL & ~roll_q;
  assign tick      = (state_q == ST_ROLL) && (cnt_q == div_q - 8'd1);

  genvar gi;
  generate
    for (gi = 0; gi < NDICE; gi++) begin : g_die
      // Candidate for die gi comes from its own nibble of rnd; values >= SIDES are rejected
      assign cand[gi]           = 4'((rnd >> (4 * gi)) & CAND_MASK);
      assign accept[gi]         = cand[gi] < 4'(SIDES);
      assign VALUES[4*gi +: 4]  = die_q[gi];
      assign dig_rot[gi]        = dig_q[(gi + NDICE - 1) % NDICE];
    end
  endgenerate

  // A restart drops all pending work; otherwise rejected dice stay pending
  // and a tick re-arms every die that is not held.
  always_comb begin
    pending_d = {NDICE{1'b0}};
    if (!roll_edge) begin
      pending_d = (pending_q & ~accept) | (tick ? ~held_q : {NDICE{1'b0}});
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_q    <= SEED;
      rc_q      <= 16'd0;
      roll_q    <= 1'b1;
      pending_q <= {NDICE{1'b0}};
    end else begin
      lfsr_q    <= lfsr_d;
      rc_q      <= rc_q + 16'd1;
      roll_q    <= ROLL;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NDICE; i++) die_q[i] <= 4'd1;
    end else if (!roll_edge) begin
      for (int i = 0; i < NDICE; i++) begin
        if (pending_q[i] && accept[i]) die_q[i] <= cand[i] + 4'd1;
      end
    end
  end

  // Roll sequencer: the tick interval grows by one each tick until DIV_END
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      div_q     <= 8'(DIV_START);
      held_q    <= {NDICE{1'b0}};
      rolling_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (roll_edge) begin
        state_q   <= ST_ROLL;
        cnt_q     <= 8'd0;
        div_q     <= 8'(DIV_START);
        held_q    <= HOLD;
        rolling_q <= 1'b1;
      end else begin
        case (state_q)
          ST_ROLL: begin
            if (tick) begin
              cnt_q <= 8'd0;
              div_q <= div_q + 8'd1;
              if ((div_q + 8'd1) == 8'(DIV_END)) state_q <= ST_SETTLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          ST_SETTLE: begin
            // Finish in the cycle the last pending die resolves
            if (pending_d == {NDICE{1'b0}}) begin
              state_q   <= ST_IDLE;
              done_q    <= 1'b1;
              rolling_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Display scan
  assign scan_wrap = (scan_q == SCW'(SCAN_DIV - 1));
  assign scan_d    = scan_wrap ? {SCW{1'b0}} : scan_q + {{(SCW-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_q <= {SCW{1'b0}};
      dig_q  <= NDICE'(1);
    end else begin
      scan_q <= scan_d;
      if (scan_wrap) dig_q <= dig_rot;
    end
  end

  always_comb begin
    sel_val = 4'd0;
    for (int i = 0; i < NDICE; i++) begin
      if (dig_q[i]) sel_val = sel_val | die_q[i];
    end
  end

  always_comb begin
    case (sel_val)
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  end

  always_comb begin
    sum_v = 6'd0;
    for (int i = 0; i < NDICE; i++) sum_v = sum_v + {2'b00, die_q[i]};
  end

  assign SUM     = sum_v;
  assign ROLLING = rolling_q;
  assign DONE    = done_q;
  assign SEG     = {~rolling_q, seg7};
  assign DIG     = dig_q;

endmodule

// File: tb/tb_multi_dice.sv
module tb_multi_dice;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: defaults
  logic roll_a = 1'b1; logic [1:0] hold_a = '0;
  logic [7:0] val_a; logic [5:0] sum_a; logic rolling_a, done_a; logic [7:0] seg_a; logic [1:0] dig_a;
  // B: timing, power-of-two sides
  logic roll_b = 1'b0; logic [1:0] hold_b = '0;
  logic [7:0] val_b; logic [5:0] sum_b; logic rolling_b, done_b; logic [7:0] seg_b; logic [1:0] dig_b;
  // C: random rolls, six sides
  logic roll_c = 1'b0; logic [2:0] hold_c = '0;
  logic [11:0] val_c; logic [5:0] sum_c; logic rolling_c, done_c; logic [7:0] seg_c; logic [2:0] dig_c;
  // D: hold mask
  logic roll_d = 1'b0; logic [2:0] hold_d = '0;
  logic [11:0] val_d; logic [5:0] sum_d; logic rolling_d, done_d; logic [7:0] seg_d; logic [2:0] dig_d;
  // E: four-digit scan
  logic roll_e = 1'b0; logic [3:0] hold_e = '0;
  logic [15:0] val_e; logic [5:0] sum_e; logic rolling_e, done_e; logic [7:0] seg_e; logic [3:0] dig_e;

  multi_dice u_a (.CLK(clk), .RST_N(rst_n), .ROLL(roll_a), .HOLD(hold_a), .VALUES(val_a), .SUM(sum_a),
                  .ROLLING(rolling_a), .DONE(done_a), .SEG(seg_a), .DIG(dig_a));
  multi_dice #(.NDICE(2), .SIDES(8), .DIV_END(5)) u_b (.CLK(clk), .RST_N(rst_n), .ROLL(roll_b), .HOLD(hold_b),
                  .VALUES(val_b), .SUM(sum_b), .ROLLING(rolling_b), .DONE(done_b), .SEG(seg_b), .DIG(dig_b));
  multi_dice #(.NDICE(3), .SIDES(6), .DIV_END(4)) u_c (.CLK(clk), .RST_N(rst_n), .ROLL(roll_c), .HOLD(hold_c),
                  .VALUES(val_c), .SUM(sum_c), .ROLLING(rolling_c), .DONE(done_c), .SEG(seg_c), .DIG(dig_c));
  multi_dice #(.NDICE(3), .SIDES(8), .DIV_END(5)) u_d (.CLK(clk), .RST_N(rst_n), .ROLL(roll_d), .HOLD(hold_d),
                  .VALUES(val_d), .SUM(sum_d), .ROLLING(rolling_d), .DONE(done_d), .SEG(seg_d), .DIG(dig_d));
  multi_dice #(.NDICE(4), .SIDES(8), .DIV_END(3), .SCAN_DIV(3)) u_e (.CLK(clk), .RST_N(rst_n), .ROLL(roll_e),
                  .HOLD(hold_e), .VALUES(val_e), .SUM(sum_e), .ROLLING(rolling_e), .DONE(done_e), .SEG(seg_e),
                  .DIG(dig_e));

  // Reference randomness source and cycle count since reset release
  logic [15:0] m_lfsr, m_rc;
  int          cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
      m_rc   <= 16'd0;
      cyc    <= 0;
    end else begin
      m_lfsr <= {m_lfsr[0], m_lfsr[15], m_lfsr[14] ^ m_lfsr[0], m_lfsr[13] ^ m_lfsr[0],
                 m_lfsr[12], m_lfsr[11] ^ m_lfsr[0], m_lfsr[10:1]};
      m_rc   <= m_rc + 16'd1;
      cyc    <= cyc + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Values after one resolution cycle with eight sides (3-bit candidates, no rejection)
  function automatic logic [15:0] newv(input logic [15:0] old, input logic [15:0] rnd, input logic [3:0] upd);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (upd[i]) r[4*i +: 4] = {1'b0, rnd[4*i +: 3]} + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [15:0] rnd_s;
  logic [15:0] tmp;
  logic [15:0] exp_e;
  logic [7:0]  exp_b;
  logic [11:0] exp_d;
  logic [3:0]  v;
  logic [8:0]  seen [3];
  logic        got_done;
  logic        bad;
  logic [1:0]  pend;
  int          idx;
  int          got;
  int          exp_done;
  int          s;

  initial begin
    // ---------------- reset with ROLL held high on A ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("a_rst_values", val_a, 8'h11);
    chk("a_rst_sum", sum_a, 6'd2);
    chk("a_rst_seg", seg_a, 8'b10000110);
    chk("a_rst_dig", dig_a, 2'b01);
    chk("a_rst_rolling", rolling_a, 1'b0);
    chk("a_rst_done", done_a, 1'b0);
    chk("c_rst_values", val_c, 12'h111);
    chk("c_rst_sum", sum_c, 6'd3);
    chk("e_rst_dig", dig_e, 4'b0001);

    // ---------------- scan on E with all dice at 1; A must not roll ----------------
    for (int k = 0; k < 12; k++) begin
      step();
      idx = (cyc / 3) % 4;
      chk("e_scan_dig", dig_e, 4'b0001 << idx);
      chk("e_scan_seg", seg_e, 8'b10000110);
      chk("a_no_roll", rolling_a, 1'b0);
    end
    chk("a_hold_values", val_a, 8'h11);

    // ---------------- short roll on E then scan the new values ----------------
    roll_e = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step();
      if (k == 0) begin
        roll_e = 1'b0;
        chk("e_rolling", rolling_e, 1'b1);
      end
      if (k == 2) rnd_s = m_lfsr + m_rc;
    end
    exp_e = newv(16'h1111, rnd_s, 4'hF);
    chk("e_done", done_e, 1'b1);
    chk("e_values", val_e, exp_e);
    for (int k = 0; k < 13; k++) begin
      step();
      idx = (cyc / 3) % 4;
      chk("e_roll_dig", dig_e, 4'b0001 << idx);
      chk("e_roll_seg", seg_e, {1'b1, enc(exp_e[4*idx +: 4])});
    end

    // ---------------- B: tick and DONE timing ----------------
    exp_b = 8'h11;
    roll_b = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      if (k == 0) roll_b = 1'b0;
      if (k == 3 || k == 6 || k == 10) begin
        tmp = newv({8'h00, exp_b}, rnd_s, 4'h3);
        exp_b = tmp[7:0];
      end
      chk("b_values", val_b, exp_b);
      chk("b_rolling", rolling_b, (k < 10));
      chk("b_done", done_b, (k == 10));
      chk("b_dp", seg_b[7], (k >= 10));
      if (k == 2 || k == 5 || k == 9) rnd_s = m_lfsr + m_rc;
    end

    // ---------------- D: hold mask 101, changed after the start edge ----------------
    exp_d = 12'h111;
    hold_d = 3'b101;
    roll_d = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      step();
      if (k == 0) begin
        roll_d = 1'b0;
        hold_d = 3'b000;
      end
      if (k == 3 || k == 6 || k == 10) begin
        tmp = newv({4'h0, exp_d}, rnd_s, 4'b0010);
        exp_d = tmp[11:0];
      end
      chk("d_values", val_d, exp_d);
      chk("d_done", done_d, (k == 10));
      if (k == 2 || k == 5 || k == 9) rnd_s = m_lfsr + m_rc;
    end

    // ---------------- C: 1000 rolls with random spacing ----------------
    for (int i = 0; i < 3; i++) seen[i] = '0;
    for (int r = 0; r < 1000; r++) begin
      repeat ($urandom_range(0, 3)) step();
      roll_c = 1'b1;
      step();
      roll_c = 1'b0;
      got_done = 1'b0;
      for (int k = 0; k < 100 && !got_done; k++) begin
        step();
        if (done_c) got_done = 1'b1;
      end
      chk("c_done_seen", got_done, 1'b1);
      s = 0;
      for (int i = 0; i < 3; i++) begin
        v = val_c[4*i +: 4];
        chk("c_range", (v >= 4'd1 && v <= 4'd6), 1'b1);
        seen[i][v] = 1'b1;
        s = s + v;
      end
      chk("c_sum", sum_c, s);
    end
    for (int i = 0; i < 3; i++) chk("c_all_faces", seen[i][6:1], 6'h3f);

    // ---------------- A: restart 500 cycles into a roll ----------------
    roll_a = 1'b0;
    step();
    roll_a = 1'b1;
    step();
    roll_a = 1'b0;
    chk("a_rolling_start", rolling_a, 1'b1);
    chk("a_dp_rolling", seg_a[7], 1'b0);
    bad = 1'b0;
    for (int k = 1; k < 500; k++) begin
      step();
      if (done_a || !rolling_a) bad = 1'b1;
    end
    roll_a = 1'b1;
    step();
    roll_a = 1'b0;
    got = 0;
    exp_done = 0;
    pend = 2'b11;
    for (int k = 1; k <= 13000 && got == 0; k++) begin
      step();
      if (done_a) got = k;
      else begin
        if (!rolling_a) bad = 1'b1;
        if (k >= 12719 && exp_done == 0) begin
          rnd_s = m_lfsr + m_rc;
          for (int i = 0; i < 2; i++) begin
            if (rnd_s[4*i +: 3] < 3'd6) pend[i] = 1'b0;
          end
          if (pend == 2'b00) exp_done = k + 1;
        end
      end
    end
    chk("a_no_early_done", bad, 1'b0);
    chk("a_done_latency", got, exp_done);
    chk("a_rolling_end", rolling_a, 1'b0);
    chk("a_dp_idle", seg_a[7], 1'b1);
    step();
    chk("a_done_pulse", done_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multi_dice.md
Name: multi_dice

Overview:
- Parametrised N-die roller for the on-board demo/game tiles; successor to the single-die 7-segment roller.
- Adds a configurable die count and side count, uniform rejection sampling, and a per-die HOLD mask (re-roll subset).
- Adds ROLL edge detection, a DONE pulse, a binary SUM output, and a multiplexed 7-segment display driver.

Parameters:
NDICE, 2, number of dice, 1..4
SIDES, 6, faces per die, 2..9; values run 1..SIDES
DIV_START, 2, initial tick interval in cycles, >=1
DIV_END, 160, interval at which the roll stops, DIV_START < DIV_END <= 255
SCAN_DIV, 16, cycles each digit is shown during multiplexing, >=1
SEED, 16'hACE1, LFSR reset value, nonzero

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
ROLL  in  1  roll request; acts on rising edge, synchronous
HOLD  in  NDICE  bit i=1 freezes die i; sampled at roll start
VALUES  out  4*NDICE  die i value in [4i+3:4i], binary 1..SIDES
SUM  out  6  sum of all die values
ROLLING  out  1  high while a roll is in progress
DONE  out  1  one-cycle pulse when a roll completes
SEG  out  8  [6:0]=segments g..a of the scanned die, active-high; [7]=dp
DIG  out  NDICE  one-hot digit enable; bit i selects die i

Behaviour:
- Reset (async assert, sync release) sets:
  - every die to 1; SUM=NDICE; ROLLING=0; DONE=0; DIG=1 (die 0).
  - lfsr=SEED; free-running counter rc=0; cnt=0; div=DIV_START; state IDLE.
  - roll_q=1, so a ROLL held high through reset does not trigger a roll.
- Randomness:
  - 16-bit LFSR advances every cycle: next = {l[0], l[15], l[14]^l[0], l[13]^l[0], l[12], l[11]^l[0], l[10:1]}.
  - rc increments every cycle, wrapping mod 2^16. Both free-run in all states.
  - rnd = lfsr + rc (mod 2^16). W = clog2(SIDES).
  - Die i candidate c_i = rnd[4i+W-1:4i].
- Edge detect: roll_q <= ROLL each cycle; edge = ROLL & ~roll_q.
- States: IDLE, ROLL, SETTLE.
- Starting a roll: an edge in any state (restart wins over every other event in that cycle) does all of the following:
  - div=DIV_START, cnt=0, held<=HOLD.
  - clears all pending flags and enters ROLL.
  - ROLLING=1 from the next cycle.
- ROLL state:
  - cnt increments each cycle. When cnt==div-1 a tick occurs: cnt=0, div=div+1, pending_i=1 for every die with held_i=0.
  - On the tick where div becomes DIV_END, go to SETTLE.
- Pending die i, any state:
  - If c_i < SIDES: die_i <= c_i+1 on the next edge and pending_i clears.
  - Otherwise retry next cycle with no value change.
  - Never rejects when SIDES is a power of two.
- SETTLE state: when no die is pending, go to IDLE. DONE=1 for exactly that one cycle and ROLLING=0 in the same cycle.
- All dice held: timing is unchanged; values stay fixed; DONE still fires.
- Roll duration with no rejections: sum of d for d=DIV_START..DIV_END-1 cycles from the edge to the last tick, then 1 cycle to DONE. Defaults: 12719+1 cycles.
- SUM is combinational from the die registers: zero-extended add, max 36, no overflow.
- Display scan:
  - A scan counter counts 0..SCAN_DIV-1. On wrap, DIG rotates left one position, wrapping from bit NDICE-1 to bit 0. With NDICE=1, DIG stays 1.
  - SEG is combinational from DIG and the selected die. dp = ~ROLLING.
  - Encodings: 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Any other value shows 0000000.
- Reset asserted mid-roll: aborts immediately to reset values; no DONE.

Test Plan:
- Reset, defaults, ROLL=1 during reset and held high afterwards -> VALUES=8'h11, SUM=2, SEG=8'b10000110, DIG=2'b01, ROLLING=0; no roll starts after release.
- DIV_START=2, DIV_END=5, SIDES=8, single ROLL pulse -> ROLLING rises 1 cycle after the edge; ticks at +2, +5, +9 cycles; DONE pulses once at +10; dp=0 while ROLLING=1, 1 afterwards; each die value changes at most once per tick.
- SIDES=6, 1000 rolls with random ROLL spacing -> every die value within 1..6; SUM equals the arithmetic sum of the dice; every value 1..6 observed at least once per die.
- NDICE=3, HOLD=3'b101, roll completes -> dice 0 and 2 bit-identical to their pre-roll values; die 1 updates; HOLD changes after the start edge have no effect.
- Second ROLL edge mid-roll (defaults, at cycle 500) -> div back to 2; DONE arrives 12720 cycles after the second edge; no DONE for the first roll.
- NDICE=4, SCAN_DIV=3 -> DIG sequence 0001, 0010, 0100, 1000, 0001, each held 3 cycles; SEG matches the encoding of the selected die.
